// File: rtl/rv_isa_pkg.sv
// RV32I field constants, op codes and word builders shared by the
// instruction encoder and the core's decode stage.
package rv_isa_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRA     = 3'b101;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_ANDI    = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [31:0] NOP_WORD  = 32'h00000013;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_XOR  = 4'd2,
        OP_SRA  = 4'd3,
        OP_ADDI = 4'd4,
        OP_ANDI = 4'd5,
        OP_LW   = 4'd6,
        OP_SW   = 4'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_TERM = 2'd2,
        ST_DONE = 2'd3
    } enc_state_e;

    function automatic logic [31:0] enc_r(
        input logic [6:0] f7,
        input logic [4:0] rs2,
        input logic [4:0] rs1,
        input logic [2:0] f3,
        input logic [4:0] rd,
        input logic [6:0] opc
    );
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(
        input logic [11:0] imm,
        input logic [4:0]  rs1,
        input logic [2:0]  f3,
        input logic [4:0]  rd,
        input logic [6:0]  opc
    );
        return {imm, rs1, f3, rd, opc};
    endfunction

    // Store immediates are split around the rs2/rs1 fields.
    function automatic logic [31:0] enc_s(
        input logic [11:0] imm,
        input logic [4:0]  rs2,
        input logic [4:0]  rs1,
        input logic [2:0]  f3,
        input logic [6:0]  opc
    );
        return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
    endfunction

endpackage

// File: rtl/rv_encode.sv
// Combinational packer: symbolic micro-op fields to one RV32I word.
// Ops outside the supported subset produce a zero word and raise illegal.
module rv_encode
    import rv_isa_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [11:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  word = enc_r(F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OPC_OP);
            OP_SUB:  word = enc_r(F7_ALT,  rs2, rs1, F3_ADD_SUB, rd, OPC_OP);
            OP_XOR:  word = enc_r(F7_BASE, rs2, rs1, F3_XOR,     rd, OPC_OP);
            OP_SRA:  word = enc_r(F7_ALT,  rs2, rs1, F3_SRA,     rd, OPC_OP);
            OP_ADDI: word = enc_i(imm, rs1, F3_ADDI, rd, OPC_OP_IMM);
            OP_ANDI: word = enc_i(imm, rs1, F3_ANDI, rd, OPC_OP_IMM);
            OP_LW:   word = enc_i(imm, rs1, F3_WORD, rd, OPC_LOAD);
            OP_SW:   word = enc_s(imm, rs2, rs1, F3_WORD, OPC_STORE);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Program loader: encodes accepted micro-ops and writes them sequentially
// into instruction memory from address 0, optionally closing with a NOP.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// LOAD    | accepting requests while memory has room
// TERM    | one cycle to write the NOP terminator if room remains
// DONE    | session closed; done high until the next start
module inst_encoder
    import rv_isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [11:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err_illegal
);

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    enc_state_e  state;
    enc_state_e  state_nxt;
    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        full;
    logic        accept;
    logic        session_start;

    rv_encode u_encode (
        .op      (in_op),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign full          = (count == FULL_CNT);
    assign in_ready      = (state == ST_LOAD) && !full;
    assign accept        = in_valid && in_ready;
    assign done          = (state == ST_DONE);
    assign session_start = start && ((state == ST_IDLE) || (state == ST_DONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reaching full takes priority over finish: there is no room for a NOP.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (full) begin
                    state_nxt = ST_DONE;
                end else if (finish) begin
                    state_nxt = ST_TERM;
                end
            end
            ST_TERM: state_nxt = ST_DONE;
            ST_DONE: if (start) state_nxt = ST_LOAD;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write port is registered; address and data hold between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 32'h0;
            count       <= '0;
            err_illegal <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (session_start) begin
                count       <= '0;
                err_illegal <= 1'b0;
            end else if (accept) begin
                if (enc_illegal) begin
                    err_illegal <= 1'b1;
                end else begin
                    mem_we    <= 1'b1;
                    mem_addr  <= count[ADDR_W-1:0];
                    mem_wdata <= enc_word;
                    count     <= count + 1'b1;
                end
            end else if ((state == ST_TERM) && !full) begin
                mem_we    <= 1'b1;
                mem_addr  <= count[ADDR_W-1:0];
                mem_wdata <= NOP_WORD;
                count     <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: a cycle-level behavioural model checked
// every cycle, plus literal instruction words from hand-assembled RV32I.
module tb_inst_encoder;

    localparam int DEPTH_M = 256;
    localparam int F3_T  [8] = '{0, 0, 4, 5, 0, 7, 2, 2};
    localparam int F7_T  [8] = '{0, 32, 0, 32, 0, 0, 0, 0};
    localparam int OPC_T [8] = '{51, 51, 51, 51, 19, 19, 3, 35};

    logic        clk = 1'b0;
    logic        reset;
    logic        start, finish, in_valid;
    logic [3:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [11:0] in_imm;
    logic        in_ready, mem_we, done, err_illegal;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  count;

    logic        s_start, s_finish, s_valid;
    logic        s_ready, s_we, s_done, s_err;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t wlog[$];
    int  s_nwr = 0;
    logic [1:0] s_last = '0;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .done(done), .err_illegal(err_illegal)
    );

    inst_encoder #(.ADDR_W(2)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .finish(s_finish),
        .in_valid(s_valid), .in_ready(s_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .count(s_count), .done(s_done), .err_illegal(s_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Field placement straight from the RV32I R/I/S layouts, table driven.
    function automatic logic [31:0] ref_word(input int op, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [11:0] imm);
        logic [31:0] w;
        w = (32'(F3_T[op]) << 12) | 32'(OPC_T[op]) | (32'(rs1) << 15);
        if (op < 4)
            w = w | (32'(F7_T[op]) << 25) | (32'(rs2) << 20) | (32'(rd) << 7);
        else if (op < 7)
            w = w | (32'(imm) << 20) | (32'(rd) << 7);
        else
            w = w | ((32'(imm) >> 5) << 25) | (32'(rs2) << 20) | ((32'(imm) & 32'd31) << 7);
        return w;
    endfunction

    // Behavioural model and per-cycle compare for the 256-deep instance.
    initial begin
        bit          loading, terminating, finished, m_err, m_we, m_ready;
        int          m_cnt, ncyc;
        logic [7:0]  m_addr;
        logic [31:0] m_data;
        loading = 0; terminating = 0; finished = 0; m_err = 0; m_we = 0;
        m_cnt = 0; ncyc = 0; m_addr = '0; m_data = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (reset) begin
                loading = 0; terminating = 0; finished = 0; m_err = 0; m_we = 0;
                m_cnt = 0; m_addr = '0; m_data = '0;
            end
            m_ready = loading && (m_cnt < DEPTH_M);
            chk("in_ready", in_ready, m_ready);
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_data);
            chk("count", count, m_cnt);
            chk("done", done, finished);
            chk("err_illegal", err_illegal, m_err);
            if (mem_we) wlog.push_back('{ncyc, mem_addr, mem_wdata});
            if (s_we) begin
                s_nwr++;
                s_last = s_addr;
            end
            if (!reset) begin
                m_we = 0;
                if (!loading && !terminating) begin
                    if (start) begin
                        loading = 1; finished = 0; m_cnt = 0; m_err = 0;
                    end
                end else if (loading) begin
                    if (in_valid && m_ready) begin
                        if (in_op > 4'd7) m_err = 1;
                        else begin
                            m_we = 1; m_addr = 8'(m_cnt);
                            m_data = ref_word(int'(in_op), in_rd, in_rs1, in_rs2, in_imm);
                            m_cnt++;
                        end
                    end
                    if (m_ready == 0 && m_cnt == DEPTH_M) begin
                        loading = 0; finished = 1;
                    end else if (finish) begin
                        loading = 0; terminating = 1;
                    end
                end else begin
                    if (m_cnt < DEPTH_M) begin
                        m_we = 1; m_addr = 8'(m_cnt); m_data = 32'h00000013; m_cnt++;
                    end
                    terminating = 0; finished = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [11:0] imm);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        step();
        finish = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 0; finish = 0; in_valid = 0;
        s_start = 0; s_finish = 0; s_valid = 0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        idle(2);
        chk("rst_count", count, 0);
        chk("rst_ready", in_ready, 0);
        reset = 1'b0;
        chk("pin_add", ref_word(0, 5'd3, 5'd1, 5'd2, 12'd0), 32'h002081B3);
        chk("pin_sw", ref_word(7, 5'd0, 5'd2, 5'd5, 12'd12), 32'h00512623);
        pulse_finish();
        idle(2);

        // ADD then SUB back to back, then terminate
        wlog.delete();
        pulse_start();
        send(4'd0, 5'd3, 5'd1, 5'd2, 12'h0);
        send(4'd1, 5'd5, 5'd6, 5'd7, 12'h0);
        chk("cnt_after_sub", count, 2);
        pulse_finish();
        idle(3);
        chk("s1_writes", wlog.size(), 3);
        chk("add_addr", wlog[0].addr, 0);
        chk("add_word", wlog[0].data, 32'h002081B3);
        chk("sub_addr", wlog[1].addr, 1);
        chk("sub_word", wlog[1].data, 32'h407302B3);
        chk("b2b_gap", wlog[1].cyc - wlog[0].cyc, 1);
        chk("s1_nop", wlog[2].data, 32'h00000013);
        chk("s1_done", done, 1);

        // SRA, ADDI -1, LW, SW, SW with rd=31 (start held during SW: ignored)
        wlog.delete();
        pulse_start();
        send(4'd3, 5'd1, 5'd2, 5'd3, 12'h0);
        send(4'd4, 5'd1, 5'd0, 5'd9, 12'hFFF);
        send(4'd6, 5'd4, 5'd2, 5'd0, 12'd8);
        send(4'd7, 5'd0, 5'd2, 5'd5, 12'd12);
        start = 1'b1;
        send(4'd7, 5'd31, 5'd2, 5'd5, 12'd12);
        start = 1'b0;
        pulse_finish();
        idle(3);
        chk("s2_writes", wlog.size(), 6);
        chk("sra_word", wlog[0].data, 32'h403150B3);
        chk("addi_word", wlog[1].data, 32'hFFF00093);
        chk("lw_word", wlog[2].data, 32'h00812203);
        chk("sw_word", wlog[3].data, 32'h00512623);
        chk("sw_rd31_word", wlog[4].data, 32'h00512623);
        chk("sw_rd31_addr", wlog[4].addr, 4);
        chk("s2_count", count, 6);

        // illegal op between two ADDs
        wlog.delete();
        pulse_start();
        send(4'd0, 5'd3, 5'd1, 5'd2, 12'h0);
        send(4'd9, 5'd3, 5'd1, 5'd2, 12'h0);
        send(4'd0, 5'd4, 5'd1, 5'd2, 12'h0);
        chk("ill_err", err_illegal, 1);
        chk("ill_count", count, 2);
        pulse_finish();
        idle(3);
        chk("ill_writes", wlog.size(), 3);
        chk("ill_addr1", wlog[1].addr, 1);
        chk("ill_nop_addr", wlog[2].addr, 2);
        chk("ill_nop", wlog[2].data, 32'h00000013);
        chk("ill_count3", count, 3);
        chk("ill_done", done, 1);
        pulse_start();
        chk("restart_err", err_illegal, 0);
        chk("restart_count", count, 0);
        chk("restart_done", done, 0);

        // reset in the cycle after a handshake
        send(4'd0, 5'd3, 5'd1, 5'd2, 12'h0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rstmid_we", mem_we, 0);
        chk("rstmid_count", count, 0);
        chk("rstmid_addr", mem_addr, 0);
        chk("rstmid_wdata", mem_wdata, 0);
        step();
        reset = 1'b0;
        idle(2);
        chk("rstmid_ready", in_ready, 0);
        chk("rstmid_done", done, 0);

        // 4-deep instance: fill to the boundary with five offered requests
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        in_op = 4'd0; in_rd = 5'd1; in_rs1 = 5'd2; in_rs2 = 5'd3; in_imm = '0;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("small_ready", s_ready, (i < 4) ? 1 : 0);
            chk("small_done_early", s_done, 0);
            step();
        end
        s_valid = 1'b0;
        chk("small_done", s_done, 1);
        chk("small_count", s_count, 4);
        s_finish = 1'b1;
        step();
        s_finish = 1'b0;
        idle(2);
        chk("small_writes", s_nwr, 4);
        chk("small_last_addr", s_last, 3);
        chk("small_word", s_wdata, 32'h003100B3);
        chk("small_count_end", s_count, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
